// File: rtl/strassen_pkg.sv
// Shared types and constants for the serial Strassen 2x2 block multiplier:
// FSM states, step count and the per-step accumulate/subtract table.
package strassen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  localparam int N_STEPS = 7;

  // Bit-pair per C element: {enable, subtract}.
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // Rows are steps M1..M7; columns are C11, C12, C21, C22.
  localparam logic [1:0] STEP_OPS [N_STEPS][4] = '{
    '{OP_ADD,  OP_NONE, OP_NONE, OP_ADD },
    '{OP_NONE, OP_NONE, OP_ADD,  OP_SUB },
    '{OP_NONE, OP_ADD,  OP_NONE, OP_ADD },
    '{OP_ADD,  OP_NONE, OP_ADD,  OP_NONE},
    '{OP_SUB,  OP_ADD,  OP_NONE, OP_NONE},
    '{OP_NONE, OP_NONE, OP_NONE, OP_ADD },
    '{OP_ADD,  OP_NONE, OP_NONE, OP_NONE}
  };

  // Ops for one step, packed by C element index; steps past the table do nothing.
  function automatic logic [3:0][1:0] ops_for(input logic [2:0] step);
    ops_for = '0;
    if (int'(step) < N_STEPS) begin
      for (int k = 0; k < 4; k++) ops_for[k] = STEP_OPS[step][k];
    end
  endfunction

endpackage

// File: rtl/strassen_mul.sv
// Signed W x W multiplier producing a full 2*W-bit product; the single
// shared multiplier of the serial Strassen block.
module strassen_mul #(
  parameter int W = 18
) (
  input  logic signed [W-1:0]   x,
  input  logic signed [W-1:0]   y,
  output logic signed [2*W-1:0] p
);

  assign p = (2*W)'(x) * (2*W)'(y);

endmodule

// File: rtl/strassen_serial.sv
// Serial 2x2 block matrix multiplier using Strassen's seven products, one per
// cycle. Define STRASSEN_SERIAL_MUL_PIPE_EN to register the multiplier output.
module strassen_serial
  import strassen_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a11,
  input  logic [WIDTH-1:0] a12,
  input  logic [WIDTH-1:0] a21,
  input  logic [WIDTH-1:0] a22,
  input  logic [WIDTH-1:0] b11,
  input  logic [WIDTH-1:0] b12,
  input  logic [WIDTH-1:0] b21,
  input  logic [WIDTH-1:0] b22,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*WIDTH:0] c11,
  output logic [2*WIDTH:0] c12,
  output logic [2*WIDTH:0] c21,
  output logic [2*WIDTH:0] c22,
  output logic             busy
);

  localparam int CW = 2*WIDTH + 1;
  localparam int EW = WIDTH + 2;
  localparam int PW = 2*EW;

`ifdef STRASSEN_SERIAL_MUL_PIPE_EN
  localparam logic [2:0] LAST_STEP = 3'(N_STEPS);
`else
  localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);
`endif

  state_t               state_q, state_d;
  logic [2:0]           step_q;
  logic                 ready_q;
  logic [WIDTH-1:0]     opa [4];
  logic [WIDTH-1:0]     opb [4];
  logic signed [PW-1:0] acc [4];

  logic signed [EW-1:0] mul_x, mul_y;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] acc_prod;
  logic [3:0][1:0]      acc_ops;
  logic                 acc_en;

  function automatic logic signed [EW-1:0] ext(input logic [WIDTH-1:0] v);
    return $signed({2'b00, v});
  endfunction

  function automatic logic signed [PW-1:0] acc_next(input logic signed [PW-1:0] cur,
                                                    input logic signed [PW-1:0] p,
                                                    input logic [1:0]           op);
    case (op)
      OP_ADD:  return cur + p;
      OP_SUB:  return cur - p;
      default: return cur;
    endcase
  endfunction

  // Operand pair for the current step (index 0..3 = x11, x12, x21, x22).
  always_comb begin
    // NOTE: defaults first, so no branch leaves a signal unassigned and infers a latch.
    mul_x = '0;
    mul_y = '0;
    case (step_q)
      3'd0: begin mul_x = ext(opa[0]) + ext(opa[3]); mul_y = ext(opb[0]) + ext(opb[3]); end
      3'd1: begin mul_x = ext(opa[2]) + ext(opa[3]); mul_y = ext(opb[0]);               end
      3'd2: begin mul_x = ext(opa[0]);               mul_y = ext(opb[1]) - ext(opb[3]); end
      3'd3: begin mul_x = ext(opa[3]);               mul_y = ext(opb[2]) - ext(opb[0]); end
      3'd4: begin mul_x = ext(opa[0]) + ext(opa[1]); mul_y = ext(opb[3]);               end
      3'd5: begin mul_x = ext(opa[2]) - ext(opa[0]); mul_y = ext(opb[0]) + ext(opb[1]); end
      3'd6: begin mul_x = ext(opa[1]) - ext(opa[3]); mul_y = ext(opb[2]) + ext(opb[3]); end
      default: ;
    endcase
  end

  strassen_mul #(.W(EW)) u_mul (
    .x (mul_x),
    .y (mul_y),
    .p (prod)
  );

`ifdef STRASSEN_SERIAL_MUL_PIPE_EN
  logic signed [PW-1:0] prod_q;
  logic [3:0][1:0]      ops_q;
  logic                 pv_q;

  // Product and its step's ops travel together; accumulation trails by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      ops_q  <= '0;
      pv_q   <= 1'b0;
    end else begin
      prod_q <= prod;
      ops_q  <= ops_for(step_q);
      pv_q   <= (state_q == COMPUTE) && (step_q < LAST_STEP);
    end
  end

  always_comb begin
    acc_en   = pv_q;
    acc_prod = prod_q;
    acc_ops  = ops_q;
  end
`else
  always_comb begin
    acc_en   = (state_q == COMPUTE);
    acc_prod = prod;
    acc_ops  = ops_for(step_q);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && in_ready)  state_d = COMPUTE;
      COMPUTE: if (step_q == LAST_STEP)   state_d = DONE;
      DONE:    if (out_ready)             state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q  <= '0;
      ready_q <= 1'b0;
      // NOTE: these small arrays are plain flops, so they are cleared like any register.
      for (int k = 0; k < 4; k++) begin
        acc[k] <= '0;
        opa[k] <= '0;
        opb[k] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        IDLE: if (in_valid && in_ready) begin
          opa[0] <= a11; opa[1] <= a12; opa[2] <= a21; opa[3] <= a22;
          opb[0] <= b11; opb[1] <= b12; opb[2] <= b21; opb[3] <= b22;
          for (int k = 0; k < 4; k++) acc[k] <= '0;
          step_q <= '0;
        end
        COMPUTE: step_q <= step_q + 3'd1;
        default: ;
      endcase
      if (acc_en) begin
        for (int k = 0; k < 4; k++) acc[k] <= acc_next(acc[k], acc_prod, acc_ops[k]);
      end
    end
  end

  // Results are only exposed in DONE, so no partial sum ever reaches c*.
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign in_ready  = ready_q && (state_q == IDLE);
  assign c11       = out_valid ? acc[0][CW-1:0] : '0;
  assign c12       = out_valid ? acc[1][CW-1:0] : '0;
  assign c21       = out_valid ? acc[2][CW-1:0] : '0;
  assign c22       = out_valid ? acc[3][CW-1:0] : '0;

endmodule

// File: tb/tb_strassen_serial.sv
// Self-checking bench for strassen_serial: directed vector table, output
// stall, mid-operation reset and random operations against a matrix-product model.
module tb_strassen_serial;

  localparam int WIDTH = 16;
  localparam int CW    = 2*WIDTH + 1;
`ifdef STRASSEN_SERIAL_MUL_PIPE_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  typedef logic [3:0][WIDTH-1:0] mat_t;
  typedef logic [3:0][CW-1:0]    res_t;

  typedef struct packed {
    mat_t a;
    mat_t b;
    res_t c;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [WIDTH-1:0] a11, a12, a21, a22, b11, b12, b21, b22;
  logic [CW-1:0]    c11, c12, c21, c22;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  strassen_serial #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a11       (a11),
    .a12       (a12),
    .a21       (a21),
    .a22       (a22),
    .b11       (b11),
    .b12       (b12),
    .b21       (b21),
    .b22       (b22),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c11       (c11),
    .c12       (c12),
    .c21       (c21),
    .c22       (c22),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: ordinary 2x2 matrix product, index 0..3 = x11, x12, x21, x22.
  function automatic res_t model(input mat_t a, input mat_t b);
    res_t c;
    c[0] = CW'(a[0]) * CW'(b[0]) + CW'(a[1]) * CW'(b[2]);
    c[1] = CW'(a[0]) * CW'(b[1]) + CW'(a[1]) * CW'(b[3]);
    c[2] = CW'(a[2]) * CW'(b[0]) + CW'(a[3]) * CW'(b[2]);
    c[3] = CW'(a[2]) * CW'(b[1]) + CW'(a[3]) * CW'(b[3]);
    return c;
  endfunction

  function automatic vec_t mk(input int x11, x12, x21, x22, y11, y12, y21, y22,
                              input logic [CW-1:0] z11, z12, z21, z22);
    vec_t v;
    v.a[0] = WIDTH'(x11); v.a[1] = WIDTH'(x12); v.a[2] = WIDTH'(x21); v.a[3] = WIDTH'(x22);
    v.b[0] = WIDTH'(y11); v.b[1] = WIDTH'(y12); v.b[2] = WIDTH'(y21); v.b[3] = WIDTH'(y22);
    v.c[0] = z11; v.c[1] = z12; v.c[2] = z21; v.c[3] = z22;
    return v;
  endfunction

  task automatic drive_operands(input mat_t a, input mat_t b);
    a11 = a[0]; a12 = a[1]; a21 = a[2]; a22 = a[3];
    b11 = b[0]; b12 = b[1]; b21 = b[2]; b22 = b[3];
  endtask

  task automatic check_result(input string tag, input res_t c);
    check({tag, " c11"}, 64'(c11), 64'(c[0]));
    check({tag, " c12"}, 64'(c12), 64'(c[1]));
    check({tag, " c21"}, 64'(c21), 64'(c[2]));
    check({tag, " c22"}, 64'(c22), 64'(c[3]));
  endtask

  // Called at a negedge; returns at the negedge after the output handshake.
  task automatic do_op(input string tag, input mat_t a, input mat_t b, input res_t c, input int hold);
    int n;
    drive_operands(a, b);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, " accept timeout"}, 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands must have been captured; scrambling the inputs proves it.
    drive_operands(mat_t'({$urandom, $urandom}), mat_t'({$urandom, $urandom}));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check({tag, " latency"}, 64'(n), 64'(LAT));
    check_result(tag, c);
    check({tag, " busy"}, 64'(busy), 64'd1);
    check({tag, " in_ready in DONE"}, 64'(in_ready), 64'd0);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " stall out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " stall in_ready"}, 64'(in_ready), 64'd0);
      check_result({tag, " stall"}, c);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " in_ready after pop"}, 64'(in_ready), 64'd1);
    check({tag, " out_valid after pop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    mat_t ra, rb;

    vecs[0] = mk(1, 0, 0, 1, 5, 6, 7, 8, 33'd5, 33'd6, 33'd7, 33'd8);
    vecs[1] = mk(1, 2, 3, 4, 5, 6, 7, 8, 33'd19, 33'd22, 33'd43, 33'd50);
    vecs[2] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                 33'h1_FFFC_0002, 33'h1_FFFC_0002, 33'h1_FFFC_0002, 33'h1_FFFC_0002);
    vecs[3] = mk(0, 5, 0, 0, 0, 0, 9, 0, 33'd45, 33'd0, 33'd0, 33'd0);

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive_operands('0, '0);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check_result("reset", '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready before first edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("in_ready after release", 64'(in_ready), 64'd1);

    // Directed table; vector 1 stalls the output for 5 cycles and the rest
    // follow back-to-back.
    for (int i = 0; i < 4; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, (i == 1) ? 5 : 0);
    end

    // Reset during COMPUTE step 3 discards the operation.
    drive_operands(vecs[3].a, vecs[3].b);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre-reset busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid reset out_valid", 64'(out_valid), 64'd0);
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    check("held reset out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after mid reset", 64'(in_ready), 64'd1);
    check("no stale out_valid", 64'(out_valid), 64'd0);
    do_op("after reset", vecs[1].a, vecs[1].b, vecs[1].c, 0);

    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < 4; k++) begin
        ra[k] = WIDTH'($urandom);
        rb[k] = WIDTH'($urandom);
      end
      do_op($sformatf("rand%0d", i), ra, rb, model(ra, rb), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
